// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit alu1 slice LSB-first,
// chaining its carry-out back in and assembling the WIDTH-bit result and flags.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_control,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       control_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             last_bit;
    logic             arith;

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign last_bit = (idx == LAST_IDX);
    assign arith    = (control_q == 3'd2) || (control_q == 3'd3);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_cin     = 1'b0;
        slice_control = 3'd0;
        if (state == RUN) begin
            slice_a       = a_q[idx];
            slice_b       = b_q[idx];
            slice_cin     = carry;
            slice_control = control_q;
        end
    end

    // Result with the current slice bit merged in, so the final edge can
    // publish out/zero/negative without an extra cycle.
    always_comb begin
        result_next      = result;
        result_next[idx] = slice_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            control_q <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= A;
                        b_q       <= B;
                        control_q <= control;
                        idx       <= '0;
                        carry     <= (control == 3'd3);
                    end
                end
                RUN: begin
                    result <= result_next;
                    carry  <= slice_cout;
                    idx    <= idx + IDX_W'(1);
                    if (last_bit) begin
                        // slice_cin here is the MSB carry-in, so no separate
                        // cin_msb register is needed for the overflow flag.
                        out       <= result_next;
                        carry_out <= slice_cout;
                        overflow  <= arith ? (slice_cin ^ slice_cout) : 1'b0;
                        zero      <= (result_next == '0);
                        negative  <= result_next[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that computes a WIDTH-bit ALU operation using one shared 1-bit ALU slice (alu1), one bit per clock, LSB first.
- Latches operands and the 3-bit control on start and presents one bit pair per cycle to the slice.
- Registers the slice carry-out and feeds it back as the next carry-in, and assembles the result and flags.
- Sits between the register-file/decode side and the single alu1 instance, which is instantiated outside this block.

Parameters:
WIDTH, 8, operand/result width; also the number of RUN cycles (legal 2..32).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
A  input  WIDTH  operand A, sampled on accepted start
B  input  WIDTH  operand B, sampled on accepted start
control  input  3  alu1 op code, sampled on accepted start (2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result and flags are valid
out  output  WIDTH  result, held until the next accepted start
carry_out  output  1  carry out of the MSB slice
overflow  output  1  signed overflow; only for control 2/3, else 0
zero  output  1  out == 0
negative  output  1  out[WIDTH-1]
slice_a  output  1  A bit to alu1
slice_b  output  1  B bit to alu1
slice_cin  output  1  carry-in to alu1
slice_control  output  3  control to alu1
slice_out  input  1  alu1 result bit
slice_cout  input  1  alu1 carry out

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (any state, including mid-RUN): state=IDLE; busy=0, done=0, out=0, carry_out=0, overflow=0, zero=0, negative=0; bit index=0; internal carry=0. Any in-flight operation is discarded with no done pulse.
- IDLE, start=1: latch A, B and control; idx=0; carry=(control==3). Next state is RUN, and busy rises on that edge.
- IDLE, start=0: stay in IDLE. Outputs hold their last values.
- RUN, combinational slice drive:
  - slice_a=A_q[idx], slice_b=B_q[idx], slice_cin=carry, slice_control=control_q.
  - Slice outputs are combinational and must be valid within the cycle.
- RUN, each edge:
  - result shift register takes slice_out at bit idx.
  - carry<=slice_cout.
  - On idx==WIDTH-1, also capture cin_msb=slice_cin.
  - Then idx<=idx+1.
- RUN, after the edge at idx==WIDTH-1: go to DONE and update outputs together:
  - out=result; carry_out=slice_cout.
  - overflow=(control_q is 2 or 3) ? cin_msb^slice_cout : 0.
  - zero=(result==0); negative=result[WIDTH-1].
- Latency: start accepted at edge N. busy=1 for cycles N+1..N+WIDTH. done=1 in cycle N+WIDTH+1 only.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE unconditionally. start asserted in DONE is ignored (not queued).
- start while busy: ignored. Latched operands and control do not change.
- Control 0/1: sequenced identically; out/carry follow whatever the slice returns; overflow=0.
- When not in RUN: slice_a=0, slice_b=0, slice_cin=0, slice_control=0.
- idx width is clog2(WIDTH). No wrap beyond WIDTH-1 is ever reached.

Test Plan:
- Bench connects a real alu1 to the slice ports; WIDTH=8.
- ADD: A=5, B=3, control=2, start pulsed 1 cycle -> busy for 8 cycles; done pulse 9 cycles after the accepting edge; out=8, carry_out=0, overflow=0, zero=0, negative=0.
- SUB: A=3, B=5, control=3 -> out=0xFE, negative=1, carry_out=0, overflow=0.
- ADD overflow: A=0x7F, B=0x01 -> out=0x80, overflow=1, negative=1. Then SUB A=0x80, B=0x01 -> out=0x7F, overflow=1, carry_out=1.
- Logic ops: AND 0xF0&0x0F -> out=0x00, zero=1, overflow=0. XOR 0xAA^0xFF -> 0x55. NOR 0x00,0x00 -> 0xFF.
- Start during busy: ADD 1+1 begun; start with A=9, B=9 pulsed at RUN cycle 3 -> result 2, exactly one done pulse, no second operation starts.
- Reset mid-run: reset at RUN cycle 4 -> next cycle busy=0, all outputs 0, no done pulse. A new start afterwards completes normally (ADD 10+20 -> out=30).
